// File: rtl/exu_operand_pipe.sv
// exu_operand_pipe: registered ALU operand selector with RAW forwarding, issue stall and a skid buffer.
// Optional feature macro EXU_OPERAND_FWD_EN: forward ready producer results; when undefined any match stalls.
module exu_operand_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_AW     = 5,
  parameter int NUM_FWD    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic                          rs1_enable_i,
  input  logic                          rs2_enable_i,
  input  logic                          memread_i,
  input  logic                          alu_2nd_src_i,
  input  logic                          jal_i,
  input  logic                          jalr_i,
  input  logic                          auipc_i,
  input  logic [REG_AW-1:0]             rs1_addr_i,
  input  logic [REG_AW-1:0]             rs2_addr_i,
  input  logic [DATA_WIDTH-1:0]         rs1_i,
  input  logic [DATA_WIDTH-1:0]         rs2_i,
  input  logic [DATA_WIDTH-1:0]         pc_i,
  input  logic [DATA_WIDTH-1:0]         imme_i,
  input  logic [DATA_WIDTH-1:0]         mem_read_i,
  input  logic [NUM_FWD-1:0]            fwd_valid_i,
  input  logic [NUM_FWD-1:0]            fwd_ready_i,
  input  logic [NUM_FWD*REG_AW-1:0]     fwd_addr_i,
  input  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_WIDTH-1:0]         alu_A_o,
  output logic [DATA_WIDTH-1:0]         alu_B_o,
  output logic [DATA_WIDTH-1:0]         pc_o,
  output logic                          stall_o,
  output logic [31:0]                   stall_cnt_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [DATA_WIDTH-1:0] LINK_OFS = DATA_WIDTH'(4);

  // Returns {hazard, value} for one source; the youngest matching producer is applied last and wins.
  function automatic logic [DATA_WIDTH:0] resolve(input logic                  en,
                                                  input logic [REG_AW-1:0]     addr,
                                                  input logic [DATA_WIDTH-1:0] rf);
    logic                  haz;
    logic [DATA_WIDTH-1:0] val;
    haz = 1'b0;
    val = rf;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (en && (addr != '0) && fwd_valid_i[k] &&
          (fwd_addr_i[k*REG_AW +: REG_AW] == addr)) begin
`ifdef EXU_OPERAND_FWD_EN
        haz = ~fwd_ready_i[k];
        val = fwd_ready_i[k] ? fwd_data_i[k*DATA_WIDTH +: DATA_WIDTH] : rf;
`else
        haz = 1'b1;
        val = rf;
`endif
      end
    end
    return {haz, val};
  endfunction

`ifndef EXU_OPERAND_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{fwd_ready_i, fwd_data_i};
`endif

  logic [DATA_WIDTH:0]   rs1_res, rs2_res;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic                  hazard, accept;

  always_comb begin
    rs1_res = resolve(rs1_enable_i, rs1_addr_i, rs1_i);
    rs2_res = resolve(rs2_enable_i, rs2_addr_i, rs2_i);
  end

  assign rs1_val = rs1_res[DATA_WIDTH-1:0];
  assign rs2_val = rs2_res[DATA_WIDTH-1:0];
  assign hazard  = rs1_res[DATA_WIDTH] | rs2_res[DATA_WIDTH];

  always_comb begin
    sel_a = '0;
    if (rs1_enable_i)                  sel_a = rs1_val;
    else if (jal_i | jalr_i | auipc_i) sel_a = pc_i;
  end

  always_comb begin
    sel_b = '0;
    if (rs2_enable_i)         sel_b = rs2_val;
    else if (alu_2nd_src_i)   sel_b = imme_i;
    else if (jal_i | jalr_i)  sel_b = LINK_OFS;
    else if (memread_i)       sel_b = mem_read_i;
  end

  logic [1:0] state_q, state_d;
  logic       in_ready_q;
  logic       load_out, load_skid, skid_to_out;

  assign stall_o = in_valid_i & hazard;
  assign accept  = in_valid_i & in_ready_q & ~hazard & ~flush_i;

  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d  = ST_ONE;
            load_out = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !out_ready_i) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (accept) begin
            load_out = 1'b1;
          end else if (out_ready_i) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready_i) begin
            state_d     = ST_ONE;
            skid_to_out = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  // Output register and skid buffer.
  logic [DATA_WIDTH-1:0] out_a_q, out_b_q, out_pc_q;
  logic [DATA_WIDTH-1:0] out_a_d, out_b_d, out_pc_d;
  logic [DATA_WIDTH-1:0] skid_a_q, skid_b_q, skid_pc_q;

  always_comb begin
    out_a_d  = out_a_q;
    out_b_d  = out_b_q;
    out_pc_d = out_pc_q;
    if (load_out) begin
      out_a_d  = sel_a;
      out_b_d  = sel_b;
      out_pc_d = pc_i;
    end else if (skid_to_out) begin
      out_a_d  = skid_a_q;
      out_b_d  = skid_b_q;
      out_pc_d = skid_pc_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_a_q  <= '0;
      out_b_q  <= '0;
      out_pc_q <= '0;
    end else begin
      out_a_q  <= out_a_d;
      out_b_q  <= out_b_d;
      out_pc_q <= out_pc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_skid) begin
      skid_a_q  <= sel_a;
      skid_b_q  <= sel_b;
      skid_pc_q <= pc_i;
    end
  end

  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != ST_EMPTY);
  assign alu_A_o     = out_a_q;
  assign alu_B_o     = out_b_q;
  assign pc_o        = out_pc_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_exu_operand_pipe.sv
// Self-checking bench for exu_operand_pipe: directed literal cases plus randomized traffic against a queue model.
module tb_exu_operand_pipe;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NF = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic flush, in_valid, out_ready;
  logic rs1_en, rs2_en, memrd, alu2, jal, jalr, auipc;
  logic [AW-1:0] rs1_addr, rs2_addr;
  logic [DW-1:0] rs1, rs2, pc, imme, memdata;
  logic [NF-1:0] fv, fr;
  logic [AW-1:0] fa [NF];
  logic [DW-1:0] fd [NF];
  logic [NF*AW-1:0] fa_p;
  logic [NF*DW-1:0] fd_p;

  logic in_ready_o, out_valid_o, stall_o;
  logic [DW-1:0] alu_A_o, alu_B_o, pc_o;
  logic [31:0] stall_cnt_o;

  assign fa_p = {fa[1], fa[0]};
  assign fd_p = {fd[1], fd[0]};

  always #5 clk = ~clk;

  exu_operand_pipe #(.DATA_WIDTH(DW), .REG_AW(AW), .NUM_FWD(NF)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .rs1_enable_i(rs1_en), .rs2_enable_i(rs2_en), .memread_i(memrd),
    .alu_2nd_src_i(alu2), .jal_i(jal), .jalr_i(jalr), .auipc_i(auipc),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_i(rs1), .rs2_i(rs2), .pc_i(pc), .imme_i(imme), .mem_read_i(memdata),
    .fwd_valid_i(fv), .fwd_ready_i(fr), .fwd_addr_i(fa_p), .fwd_data_i(fd_p),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready),
    .alu_A_o(alu_A_o), .alu_B_o(alu_B_o), .pc_o(pc_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ordered queue of launched operand sets (front is what the ALU sees).
  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] p;
  } op_t;
  op_t mq[$];
  logic [31:0] m_cnt = 32'd0;

  function automatic int winner(input logic en, input logic [AW-1:0] addr);
    if (!en || addr == 0) return -1;
    for (int k = 0; k < NF; k++)
      if (fv[k] && fa[k] == addr) return k;
    return -1;
  endfunction

  function automatic logic src_haz(input int w);
`ifdef EXU_OPERAND_FWD_EN
    return (w >= 0) && !fr[w];
`else
    return (w >= 0);
`endif
  endfunction

  function automatic logic [DW-1:0] src_val(input int w, input logic [DW-1:0] rf);
`ifdef EXU_OPERAND_FWD_EN
    if (w >= 0 && fr[w]) return fd[w];
`endif
    return rf;
  endfunction

  function automatic logic m_haz();
    return src_haz(winner(rs1_en, rs1_addr)) || src_haz(winner(rs2_en, rs2_addr));
  endfunction

  function automatic op_t m_op();
    op_t o;
    o.p = pc;
    if (rs1_en)                   o.a = src_val(winner(rs1_en, rs1_addr), rs1);
    else if (jal || jalr || auipc) o.a = pc;
    else                          o.a = '0;
    if (rs2_en)          o.b = src_val(winner(rs2_en, rs2_addr), rs2);
    else if (alu2)       o.b = imme;
    else if (jal || jalr) o.b = 64'd4;
    else if (memrd)      o.b = memdata;
    else                 o.b = '0;
    return o;
  endfunction

  // Advance one clock, applying the model to the inputs present at the edge.
  task automatic cyc();
    logic acc;
    @(posedge clk);
    if (rst_n) begin
      acc = in_valid && (mq.size() < 2) && !m_haz() && !flush;
      if (in_valid && m_haz() && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (flush) mq.delete();
      else begin
        if (out_ready && mq.size() > 0) void'(mq.pop_front());
        if (acc) mq.push_back(m_op());
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 64'(out_valid_o), 64'(mq.size() != 0));
      check("in_ready", 64'(in_ready_o), 64'(mq.size() < 2));
      check("stall", 64'(stall_o), 64'(in_valid && m_haz()));
      check("stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
      if (mq.size() != 0) begin
        check("alu_A", alu_A_o, mq[0].a);
        check("alu_B", alu_B_o, mq[0].b);
        check("pc", pc_o, mq[0].p);
      end
    end
  end

  task automatic idle();
    in_valid = 0; flush = 0;
    rs1_en = 0; rs2_en = 0; memrd = 0; alu2 = 0; jal = 0; jalr = 0; auipc = 0;
    rs1_addr = 0; rs2_addr = 0; rs1 = 0; rs2 = 0; pc = 0; imme = 0; memdata = 0;
    fv = 0; fr = 0;
    for (int k = 0; k < NF; k++) begin fa[k] = 0; fd[k] = 0; end
  endtask

  task automatic rand_inputs();
    in_valid = ($urandom_range(0, 9) < 8);
    flush    = ($urandom_range(0, 19) == 0);
    out_ready = ($urandom_range(0, 3) != 0);
    rs1_en = 1'($urandom_range(0, 1)); rs2_en = 1'($urandom_range(0, 1));
    memrd  = 1'($urandom_range(0, 1)); alu2 = ($urandom_range(0, 2) == 0);
    jal    = ($urandom_range(0, 3) == 0); jalr = ($urandom_range(0, 3) == 0);
    auipc  = ($urandom_range(0, 3) == 0);
    rs1_addr = 5'($urandom_range(0, 3)); rs2_addr = 5'($urandom_range(0, 3));
    rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom}; pc = {$urandom, $urandom};
    imme = {$urandom, $urandom}; memdata = {$urandom, $urandom};
    fv = 2'($urandom_range(0, 3));
    for (int k = 0; k < NF; k++) begin
      fr[k] = ($urandom_range(0, 3) != 0);
      fa[k] = 5'($urandom_range(0, 3));
      fd[k] = {$urandom, $urandom};
    end
  endtask

  task automatic push_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
    idle(); in_valid = 1; rs1_en = 1; rs2_en = 1; rs1_addr = 1; rs2_addr = 2; rs1 = a; rs2 = b;
    cyc();
  endtask

  initial begin
    idle();
    out_ready = 1;
    rst_n = 1;
    #1 rst_n = 0;
    mq.delete(); m_cnt = 0;
    #1 chk_en = 1;
    cyc(); cyc();
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    check("rst_A", alu_A_o, 64'd0);
    check("rst_B", alu_B_o, 64'd0);
    check("rst_pc", pc_o, 64'd0);
    check("rst_cnt", 64'(stall_cnt_o), 64'd0);
    rst_n = 1;

    // Plain ALU op
    push_op(64'd5, 64'd7);
    check("alu_valid", 64'(out_valid_o), 64'd1);
    check("alu_A5", alu_A_o, 64'd5);
    check("alu_B7", alu_B_o, 64'd7);

    idle(); in_valid = 1; jal = 1; pc = 64'h8000_0000;
    cyc();
    check("jal_A", alu_A_o, 64'h8000_0000);
    check("jal_B", alu_B_o, 64'd4);
    idle(); in_valid = 1; auipc = 1; alu2 = 1; imme = 64'h1000; pc = 64'h8000_0000;
    cyc();
    check("auipc_A", alu_A_o, 64'h8000_0000);
    check("auipc_B", alu_B_o, 64'h1000);

`ifdef EXU_OPERAND_FWD_EN
    idle(); in_valid = 1; rs1_en = 1; rs1_addr = 3; rs1 = 64'h77;
    fv = 2'b11; fr = 2'b11; fa[0] = 3; fa[1] = 3; fd[0] = 64'hAA; fd[1] = 64'hBB;
    cyc();
    check("fwd_prio_A", alu_A_o, 64'hAA);
`endif
    idle(); in_valid = 1; rs1_en = 1; rs1_addr = 0; rs1 = 64'h99;
    fv = 2'b01; fr = 2'b01; fa[0] = 0; fd[0] = 64'hAA;
    cyc();
    check("x0_A", alu_A_o, 64'h99);

    // Load-use stall on rs2 against producer 0
    idle(); in_valid = 1; rs2_en = 1; rs2_addr = 5; rs2 = 64'h55;
    fv = 2'b01; fr = 2'b00; fa[0] = 5; fd[0] = 64'h1234;
    for (int i = 0; i < 3; i++) begin
      #1 check("lu_stall", 64'(stall_o), 64'd1);
      cyc();
    end
    check("lu_cnt", 64'(stall_cnt_o), 64'd3);
    check("lu_noacc", 64'(out_valid_o), 64'd0);
`ifdef EXU_OPERAND_FWD_EN
    fr = 2'b01;
    #1 check("lu_release", 64'(stall_o), 64'd0);
    cyc();
    check("lu_B", alu_B_o, 64'h1234);
`else
    fv = 2'b00;
    #1 check("lu_release", 64'(stall_o), 64'd0);
    cyc();
    check("lu_B", alu_B_o, 64'h55);
`endif

    // Backpressure fills the skid, then drains in order
    idle(); cyc();
    out_ready = 0;
    push_op(64'h11, 64'h22);
    push_op(64'h33, 64'h44);
    idle();
    check("bp_in_ready", 64'(in_ready_o), 64'd0);
    check("bp_hold_A", alu_A_o, 64'h11);
    cyc();
    check("bp_still_A", alu_A_o, 64'h11);
    out_ready = 1;
    cyc();
    check("bp_Y_A", alu_A_o, 64'h33);
    check("bp_Y_B", alu_B_o, 64'h44);
    cyc();
    check("bp_drained", 64'(out_valid_o), 64'd0);

    // Flush while FULL with a pending issue
    out_ready = 0;
    push_op(64'h1, 64'h2);
    push_op(64'h3, 64'h4);
    idle(); in_valid = 1; rs1_en = 1; rs1 = 64'h5; flush = 1;
    cyc();
    check("fl_valid", 64'(out_valid_o), 64'd0);
    check("fl_in_ready", 64'(in_ready_o), 64'd1);
    idle(); cyc();
    check("fl_noacc", 64'(out_valid_o), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2 rst_n = 0;
        mq.delete(); m_cnt = 0;
        cyc(); cyc();
        #3 rst_n = 1;
      end
      rand_inputs();
      cyc();
    end

    idle(); out_ready = 1;
    cyc(); cyc();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/exu_operand_pipe.md
# exu_operand_pipe

Registered, flow-controlled successor to the combinational execute-stage operand selector. Selects ALU operands A/B from register-file reads, PC, immediate, load data or in-flight results (operand forwarding), and launches them through a one-entry output register backed by a one-entry skid buffer. Sits between ID/EX issue and the ALU. Detects RAW hazards against pending producers and stalls issue.

## Interface
- `DATA_WIDTH`, 64, operand width
- `REG_AW`, 5, register address width
- `NUM_FWD`, 2, forwarding sources; index 0 is the youngest and has the highest priority

- `clk_i`  in  1  clock
- `rst_n_i`  in  1  reset; asynchronous, active-low
- `flush_i`  in  1  squash all held operands
- `in_valid_i` / `in_ready_o`  in/out  1  issue handshake
- `rs1_enable_i`, `rs2_enable_i`, `memread_i`, `alu_2nd_src_i`, `jal_i`, `jalr_i`, `auipc_i`  in  1 each  decode controls
- `rs1_addr_i`, `rs2_addr_i`  in  REG_AW  source register indices
- `rs1_i`, `rs2_i`, `pc_i`, `imme_i`, `mem_read_i`  in  DATA_WIDTH  operand sources
- `fwd_valid_i`  in  NUM_FWD  producer will write a register
- `fwd_ready_i`  in  NUM_FWD  producer data is valid this cycle; low means a load is in flight
- `fwd_addr_i`  in  NUM_FWD*REG_AW  producer destination indices
- `fwd_data_i`  in  NUM_FWD*DATA_WIDTH  producer results
- `out_valid_o` / `out_ready_i`  out/in  1  ALU handshake
- `alu_A_o`, `alu_B_o`, `pc_o`  out  DATA_WIDTH  registered operands and PC
- `stall_o`  out  1  combinational; `in_valid_i` is high and a hazard exists
- `stall_cnt_o`  out  32  saturating count of stall cycles

## Operation
- **Source match.** Source s (rs1/rs2) matches producer k when all of these hold:
  - the source's enable is set
  - its address is nonzero
  - `fwd_valid_i[k]` is set
  - the addresses are equal
  - The lowest matching k wins.
- **rs1 value.** Forwarded data if the winning match has `fwd_ready_i` set, otherwise `rs1_i`.
- **A select.**
  - `rs1_enable_i` selects the rs1 value.
  - Otherwise `jal_i`, `jalr_i` or `auipc_i` selects `pc_i`.
  - Otherwise 0.
- **B select, in priority order.**
  - `rs2_enable_i` selects the rs2 value.
  - `alu_2nd_src_i` selects `imme_i`.
  - `jal_i` or `jalr_i` selects 4, zero-extended.
  - `memread_i` selects `mem_read_i`.
  - Otherwise 0.
- **Hazard.** A source's winning match has `fwd_ready_i` low.
- **Accept.** `in_valid_i & in_ready_o & ~hazard & ~flush_i`.
- **State:**
  - EMPTY: output register invalid
  - ONE: output register valid, skid empty
  - FULL: output register valid, skid valid
- **Transitions:**
  - EMPTY + accept → ONE.
  - ONE + accept + output held (`~out_ready_i`) → FULL; the new operands go to the skid buffer.
  - ONE + accept + `out_ready_i` → ONE; the output register is overwritten.
  - ONE + `out_ready_i` with no accept → EMPTY.
  - FULL + `out_ready_i` → ONE; skid moves to the output register.
  - `in_ready_o` = ~FULL, registered.
  - `flush_i` → EMPTY next edge. Flush overrides accept and `out_ready_i`.
- **stall_cnt_o.** Increments on every cycle with `stall_o` high and `flush_i` low. Saturates at 0xFFFF_FFFF.
- **Reset values.**
  - `out_valid_o`=0, `in_ready_o`=1.
  - `alu_A_o`, `alu_B_o`, `pc_o` = 0.
  - `stall_cnt_o`=0.
  - State is EMPTY.

## Timing
- Latency: operands sampled at an accepting edge appear on `alu_*_o` with `out_valid_o`=1 after that edge (1 cycle).
- Throughput is 1 per cycle while `out_ready_i` is high.
- `out_valid_o` and `alu_*_o` stay stable while `out_ready_i` is low.
- Forwarded data is sampled in the accept cycle. Later changes of `fwd_*` do not affect held operands.
- Hazard and forwarding logic is combinational from `fwd_*` and the `in_*` inputs to `stall_o` only. There is no combinational path from `out_ready_i` to `in_ready_o`.
- Reset deassertion mid-transfer discards all held operands. The first accept is possible on the first edge after `rst_n_i` rises.

## Configuration
- `EXU_OPERAND_FWD_EN` defined:
  - Forwarding and pending-load hazards are as in Operation.
- `EXU_OPERAND_FWD_EN` undefined:
  - `fwd_data_i` and `fwd_ready_i` are ignored.
  - Any source match is a hazard, regardless of `fwd_ready_i`.
  - Operands always come from `rs1_i` / `rs2_i`.
  - The stall clears when the producer drops `fwd_valid_i`.

## Test plan
- **Reset and ALU op.**
  - Stimulus: reset; then accept with `rs1_enable_i`=1, `rs2_enable_i`=1, `rs1_i`=5, `rs2_i`=7.
  - Response: next cycle `out_valid_o`=1, A=5, B=7. During reset all outputs are 0 and `in_ready_o`=1.
- **JAL operands.**
  - Stimulus: `jal_i`=1, `pc_i`=0x8000_0000.
  - Response: A=0x8000_0000, B=4. With `auipc_i`=1, `alu_2nd_src_i`=1, `imme_i`=0x1000: A=pc, B=0x1000.
- **Forwarding priority (FWD_EN).**
  - Stimulus: rs1=x3; producer 0 and producer 1 both write x3 with `fwd_ready_i`=11, data 0xAA and 0xBB.
  - Response: A=0xAA. With rs1=x0 and a producer writing x0, A=`rs1_i`.
- **Load-use stall.**
  - Stimulus: producer 0 matches rs2 with `fwd_ready_i[0]`=0 for 3 cycles.
  - Response: `stall_o`=1 and no accept for 3 cycles; `stall_cnt_o`=3. When `fwd_ready_i` rises, accept happens and B equals the forwarded data.
- **Backpressure and skid.**
  - Stimulus: `out_ready_i`=0; issue ops X and Y back-to-back.
  - Response: state FULL, `in_ready_o`=0, output holds X. When `out_ready_i` rises: X, then Y, in order with no loss.
- **Flush.**
  - Stimulus: assert `flush_i` in FULL with `in_valid_i`=1.
  - Response: next cycle `out_valid_o`=0, `in_ready_o`=1, nothing accepted.
